// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared state encoding and result-narrowing helper for the
//               running-product multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    // Widest accumulator the helper function can narrow.
    localparam int C_MAX_WIDTH = 64;

    typedef logic [2*C_MAX_WIDTH-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } mac_state_e;

    // Narrow a double-width product to `width` bits: plain truncation, or
    // clamp to all-ones when `sat` is set and the upper half is non-zero.
    function automatic wide_t sat_trunc(input wide_t       partial,
                                        input int unsigned width,
                                        input logic        sat);
        wide_t w_mask;
        wide_t w_low;
        w_mask = (wide_t'(1) << width) - wide_t'(1);
        w_low  = partial & w_mask;
        if (sat && ((partial >> width) != '0)) begin
            w_low = w_mask;
        end
        return w_low;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_add_step.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_step
// Description : One iteration of the shift-add multiplier: conditionally adds
//               the accumulator shifted by the bit position to the partial.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_step #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic [2*WIDTH-1:0] i_partial,
    input  logic [WIDTH-1:0]   i_acc,
    input  logic               i_bit,
    input  logic [CNT_W-1:0]   i_cnt,
    output logic [2*WIDTH-1:0] o_partial_next
);

    logic [2*WIDTH-1:0] w_addend;

    // Add acc<<cnt when the current multiplier bit is set.
    always_comb begin
        w_addend = '0;
        if (i_bit) begin
            w_addend = {{WIDTH{1'b0}}, i_acc} << i_cnt;
        end
        o_partial_next = i_partial + w_addend;
    end

endmodule
`default_nettype wire

// File: rtl/mac_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : mac_multiplier
// Description : Running-product unit, acc <= acc * operand per accepted
//               operand, computed over WIDTH shift-add cycles with
//               valid/ready intake, wrap or saturate narrowing and a sticky
//               overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_multiplier
    import mac_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INIT     = WIDTH'(1),
    parameter int               SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_operand,
    input  logic             in_clear,
    output logic [WIDTH-1:0] out_value,
    output logic             out_valid,
    output logic             busy,
    output logic             overflow
);

    localparam int C_CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > C_MAX_WIDTH) begin : g_bad_width
        $error("mac_multiplier: WIDTH out of supported range");
    end

    mac_state_e           r_state;
    mac_state_e           w_state_next;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]     r_operand;
    logic [2*WIDTH-1:0]   r_partial;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_overflow;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_upper_nz;
    logic [2*WIDTH-1:0]   w_partial_next;
    logic [WIDTH-1:0]     w_result;

    // Clear takes priority over a same-cycle operand, so ready drops with it.
    assign in_ready   = (r_state == IDLE) && !in_clear;
    assign w_accept   = in_valid && in_ready;
    assign w_last     = (r_cnt == C_CNT_W'(WIDTH - 1));
    assign w_upper_nz = |w_partial_next[2*WIDTH-1:WIDTH];
    assign w_result   = WIDTH'(sat_trunc(wide_t'(w_partial_next), WIDTH, SATURATE != 0));

    assign out_value  = r_acc;
    assign out_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign overflow   = r_overflow;

    // The operand register shifts right each MULT cycle, so its LSB is
    // always multiplier bit[cnt].
    shift_add_step #(
        .WIDTH (WIDTH),
        .CNT_W (C_CNT_W)
    ) u_step (
        .i_partial      (r_partial),
        .i_acc          (r_acc),
        .i_bit          (r_operand[0]),
        .i_cnt          (r_cnt),
        .o_partial_next (w_partial_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: accept -> WIDTH multiply cycles -> one result cycle; clear aborts.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = MULT;
            MULT:    if (w_last)   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (in_clear) begin
            w_state_next = IDLE;
        end
    end

    // Datapath: operand capture, iterative accumulation and result commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= INIT;
            r_overflow <= 1'b0;
            r_operand  <= '0;
            r_partial  <= '0;
            r_cnt      <= '0;
        end else if (in_clear) begin
            r_acc      <= INIT;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_operand <= in_operand;
                        r_partial <= '0;
                        r_cnt     <= '0;
                    end
                end
                MULT: begin
                    r_partial <= w_partial_next;
                    r_cnt     <= r_cnt + C_CNT_W'(1);
                    r_operand <= {1'b0, r_operand[WIDTH-1:1]};
                    if (w_last) begin
                        r_acc      <= w_result;
                        r_overflow <= r_overflow | w_upper_nz;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_multiplier
// Description : Self-checking bench for mac_multiplier. A wrapping and a
//               saturating instance share all inputs; expected results are
//               queued when an operand is accepted and checked on out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_multiplier;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_operand;
    logic       in_clear;

    logic       in_ready_w, out_valid_w, busy_w, overflow_w;
    logic [7:0] out_value_w;
    logic       in_ready_s, out_valid_s, busy_s, overflow_s;
    logic [7:0] out_value_s;

    mac_multiplier #(.WIDTH(8), .INIT(8'd1), .SATURATE(0)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_w),
        .in_operand (in_operand),
        .in_clear   (in_clear),
        .out_value  (out_value_w),
        .out_valid  (out_valid_w),
        .busy       (busy_w),
        .overflow   (overflow_w)
    );

    mac_multiplier #(.WIDTH(8), .INIT(8'd1), .SATURATE(1)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_s),
        .in_operand (in_operand),
        .in_clear   (in_clear),
        .out_value  (out_value_s),
        .out_valid  (out_valid_s),
        .busy       (busy_s),
        .overflow   (overflow_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] w;
        logic [7:0] s;
        bit         ow;
        bit         os;
        int         acc_cyc;
    } exp_t;

    exp_t q[$];

    typedef struct {
        bit         clr;
        bit         chk_gap;
        logic [7:0] op;
        logic [7:0] ew;
        logic [7:0] es;
        bit         ow;
        bit         os;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (out_valid_w || out_valid_s)) begin
            exp_t e;
            pulses++;
            chk("valid_w", int'(out_valid_w), 1);
            chk("valid_s", int'(out_valid_s), 1);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got pulse expected none (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("value_wrap", int'(out_value_w), int'(e.w));
                chk("value_sat",  int'(out_value_s), int'(e.s));
                chk("ovf_wrap",   int'(overflow_w),  int'(e.ow));
                chk("ovf_sat",    int'(overflow_s),  int'(e.os));
                chk("latency",    cyc - e.acc_cyc,   9);
            end
        end
    end

    // Present an operand until accepted; optionally queue its expected result.
    task automatic send(input logic [7:0] op, input bit push, input exp_t e,
                        output int acc_cyc);
        int waited = 0;
        in_valid   = 1'b1;
        in_operand = op;
        #1;
        while (!in_ready_w && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready_w) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 (cycle %0d)", cyc);
            acc_cyc  = -1;
            in_valid = 1'b0;
        end else begin
            acc_cyc = cyc;
            if (push) begin
                e.acc_cyc = cyc;
                q.push_back(e);
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        #1;
        while ((q.size() != 0 || busy_w) && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() != 0 || busy_w) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got pending=%0d expected 0", q.size());
        end
    endtask

    task automatic check_init(input string tag);
        chk({tag, "_value_w"}, int'(out_value_w), 1);
        chk({tag, "_value_s"}, int'(out_value_s), 1);
        chk({tag, "_valid"},   int'(out_valid_w | out_valid_s), 0);
        chk({tag, "_ovf"},     int'(overflow_w | overflow_s), 0);
        chk({tag, "_busy"},    int'(busy_w | busy_s), 0);
        chk({tag, "_ready_w"}, int'(in_ready_w), 1);
        chk({tag, "_ready_s"}, int'(in_ready_s), 1);
    endtask

    task automatic run_vec(input int i, inout int prev_acc);
        exp_t e;
        int   k;
        if (vecs[i].clr) begin
            wait_idle();
            in_clear = 1'b1;
            @(negedge clk);
            in_clear = 1'b0;
        end
        e.w = vecs[i].ew; e.s = vecs[i].es;
        e.ow = vecs[i].ow; e.os = vecs[i].os; e.acc_cyc = 0;
        send(vecs[i].op, 1'b1, e, k);
        if (vecs[i].chk_gap) chk("throughput_gap", k - prev_acc, 10);
        prev_acc = k;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int   prev_acc = 0;
        int   k;
        int   p0;
        exp_t e;

        //           clr   gap   op      wrap    sat     ow  os
        vecs[0] = '{1'b1, 1'b0, 8'd3,   8'd3,   8'd3,   0, 0};
        vecs[1] = '{1'b0, 1'b1, 8'd5,   8'd15,  8'd15,  0, 0};
        vecs[2] = '{1'b1, 1'b0, 8'd16,  8'd16,  8'd16,  0, 0};
        vecs[3] = '{1'b0, 1'b1, 8'd16,  8'd0,   8'd255, 1, 1};
        vecs[4] = '{1'b0, 1'b1, 8'd3,   8'd0,   8'd255, 1, 1};
        vecs[5] = '{1'b1, 1'b0, 8'd7,   8'd7,   8'd7,   0, 0};
        vecs[6] = '{1'b0, 1'b1, 8'd9,   8'd63,  8'd63,  0, 0};
        vecs[7] = '{1'b0, 1'b1, 8'd255, 8'd193, 8'd255, 1, 1};
        vecs[8] = '{1'b0, 1'b0, 8'd0,   8'd0,   8'd0,   0, 0};
        vecs[9] = '{1'b0, 1'b1, 8'd5,   8'd0,   8'd0,   0, 0};

        rst = 1'b1; in_valid = 1'b0; in_operand = '0; in_clear = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check_init("reset");
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i, prev_acc);

        // Reset with clear asserted in the middle of a multiply.
        wait_idle();
        e = '{8'd0, 8'd0, 0, 0, 0};
        send(8'd200, 1'b0, e, k);
        repeat (3) @(negedge clk);
        p0 = pulses;
        rst = 1'b1; in_clear = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_clear = 1'b0;
        #1;
        check_init("midrst");
        repeat (12) @(negedge clk);
        chk("no_pulse_after_rst", pulses, p0);

        for (int i = 8; i < 10; i++) run_vec(i, prev_acc);

        // Abort an in-flight multiply with a clear pulse.
        wait_idle();
        send(8'd200, 1'b0, e, k);
        repeat (2) @(negedge clk);
        p0 = pulses;
        in_clear = 1'b1;
        #1;
        chk("abort_ready_low", int'(in_ready_w), 0);
        @(negedge clk);
        in_clear = 1'b0;
        #1;
        check_init("abort");
        repeat (12) @(negedge clk);
        chk("no_pulse_after_abort", pulses, p0);

        // Clear and a valid operand in the same cycle: the operand is refused.
        in_clear = 1'b1; in_valid = 1'b1; in_operand = 8'd77;
        #1;
        chk("clear_blocks_ready", int'(in_ready_w), 0);
        @(negedge clk);
        in_clear = 1'b0; in_valid = 1'b0;
        #1;
        chk("clear_blocks_accept", int'(busy_w), 0);
        @(negedge clk);
        e = '{8'd3, 8'd3, 0, 0, 0};
        send(8'd3, 1'b1, e, k);

        wait_idle();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
